spike_bitmap_fifo_writer: RTL and testbench

- Producer side of the input-spike FIFO that the charge controller drains.
- The host writes an N-bit input-spike bitmap over an OBI slave port, then issues GO.
- The block scans the bitmap one bit per cycle and pushes the index of every set bit into the FIFO, honouring FIFO_full_i.
- It then raises spikecore_done_o, which the controller samples before it reads the FIFO.

---
 rtl/spike_bitmap_fifo_writer.sv | 170 +++++++++++++++++
 tb/tb_spike_bitmap_fifo_writer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_bitmap_fifo_writer.sv
// Input-spike FIFO producer: host loads a spike bitmap over OBI, then GO scans it one bit per
// cycle and pushes the index of every set bit into the charge controller's FIFO.
package spike_bitmap_fifo_writer_pkg;
    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_rsp_t;
endpackage

module spike_bitmap_fifo_writer #(
    parameter int unsigned N     = 256,
    parameter int unsigned M     = 8,
    parameter type         req_t = spike_bitmap_fifo_writer_pkg::obi_req_t,
    parameter type         rsp_t = spike_bitmap_fifo_writer_pkg::obi_rsp_t
) (
    input  logic         CLK,
    input  logic         RSTN,
    input  req_t         obi_slave_req_i,
    output rsp_t         obi_slave_resp_o,
    output logic         FIFO_w_en_o,
    output logic [M-1:0] FIFO_w_data_o,
    input  logic         FIFO_full_i,
    output logic         spikecore_done_o,
    output logic         busy_o
);

    localparam int unsigned NumWords   = N / 32;
    localparam int unsigned IdxW       = $clog2(N);
    localparam int unsigned LastIdxInt = N - 1;
    localparam logic [5:0]  CtrlWord   = 6'(NumWords);
    localparam logic [5:0]  StatusWord = 6'(NumWords + 1);
    localparam logic [M:0]  CountMax   = N[M:0];
    localparam logic [M:0]  LastIdx    = LastIdxInt[M:0];

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   bitmap_q, bitmap_d;
    logic [M:0]     idx_q, idx_d;
    logic [M:0]     count_q, count_d;
    logic           rvalid_q;
    logic [31:0]    rdata_q, rdata_d;

    logic [5:0]     word_addr;
    logic           wr_en, rd_en, ctrl_wr, go, clear;
    logic           cur_bit, push;
    logic           unused_addr;

    assign word_addr   = obi_slave_req_i.addr[7:2];
    assign unused_addr = ^{obi_slave_req_i.addr[31:8], obi_slave_req_i.addr[1:0]};
    assign wr_en       = obi_slave_req_i.req & obi_slave_req_i.we;
    assign rd_en       = obi_slave_req_i.req & ~obi_slave_req_i.we;
    assign ctrl_wr     = wr_en && (word_addr == CtrlWord);
    // CLEAR dominates GO when both are set in one write.
    assign clear       = ctrl_wr && obi_slave_req_i.wdata[1];
    assign go          = ctrl_wr && obi_slave_req_i.wdata[0] && !obi_slave_req_i.wdata[1];

    assign cur_bit = bitmap_q[idx_q[IdxW-1:0]];
    assign push    = (state_q == StScan) && cur_bit && !FIFO_full_i;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (go) begin
                    state_d = StScan;
                    idx_d   = '0;
                    count_d = '0;
                end
            end
            StScan: begin
                // A set bit with the FIFO full holds the scan on the same index.
                if (!cur_bit || !FIFO_full_i) begin
                    idx_d = idx_q + 1'b1;
                    if (push && (count_q != CountMax)) begin
                        count_d = count_q + 1'b1;
                    end
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (clear) begin
            state_d = StIdle;
            idx_d   = '0;
            count_d = '0;
        end
    end

    // The bitmap is frozen while a scan is in flight.
    always_comb begin
        bitmap_d = bitmap_q;
        if (wr_en && (state_q != StScan)) begin
            for (int w = 0; w < int'(NumWords); w++) begin
                for (int b = 0; b < 4; b++) begin
                    if ((word_addr == 6'(w)) && obi_slave_req_i.be[b]) begin
                        bitmap_d[32*w + 8*b +: 8] = obi_slave_req_i.wdata[8*b +: 8];
                    end
                end
            end
        end
        if (clear) begin
            bitmap_d = '0;
        end
    end

    always_comb begin
        rdata_d = '0;
        if (rd_en) begin
            for (int w = 0; w < int'(NumWords); w++) begin
                if (word_addr == 6'(w)) begin
                    rdata_d = bitmap_q[32*w +: 32];
                end
            end
            if (word_addr == StatusWord) begin
                rdata_d[0]     = (state_q == StScan);
                rdata_d[1]     = (state_q == StDone);
                rdata_d[M+8:8] = count_q;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= StIdle;
            bitmap_q <= '0;
            idx_q    <= '0;
            count_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            bitmap_q <= bitmap_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
            rvalid_q <= obi_slave_req_i.req;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        obi_slave_resp_o        = '0;
        obi_slave_resp_o.gnt    = obi_slave_req_i.req;
        obi_slave_resp_o.rvalid = rvalid_q;
        obi_slave_resp_o.rdata  = rdata_q;
    end

    assign FIFO_w_en_o      = push;
    assign FIFO_w_data_o    = push ? idx_q[M-1:0] : '0;
    assign busy_o           = (state_q == StScan);
    assign spikecore_done_o = (state_q == StDone);

endmodule

// File: tb/tb_spike_bitmap_fifo_writer.sv
// Randomized scoreboard bench for spike_bitmap_fifo_writer: expected pushes and read data are
// queued by the stimulus and drained by a negedge monitor.
module tb_spike_bitmap_fifo_writer;
    import spike_bitmap_fifo_writer_pkg::*;

    localparam int N  = 256;
    localparam int M  = 8;
    localparam int NW = N / 32;
    localparam logic [31:0] CtrlAddr   = 32'(NW * 4);
    localparam logic [31:0] StatusAddr = 32'((NW + 1) * 4);

    logic         CLK  = 1'b0;
    logic         RSTN = 1'b0;
    obi_req_t     req;
    obi_rsp_t     rsp;
    logic         w_en;
    logic [M-1:0] w_data;
    logic         full;
    logic         done;
    logic         busy;

    spike_bitmap_fifo_writer #(.N(N), .M(M)) dut (
        .CLK              (CLK),
        .RSTN             (RSTN),
        .obi_slave_req_i  (req),
        .obi_slave_resp_o (rsp),
        .FIFO_w_en_o      (w_en),
        .FIFO_w_data_o    (w_data),
        .FIFO_full_i      (full),
        .spikecore_done_o (done),
        .busy_o           (busy)
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          go_cyc = 0;
    bit          scanning = 0;
    logic        req_seen = 1'b0;
    logic [31:0] mwords [NW];
    bit          full_pat [N*4];
    int          push_q [$];
    int          push_rel_q [$];
    logic [31:0] rd_q [$];

    always @(posedge CLK) begin
        cyc      <= cyc + 1;
        req_seen <= req.req;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every rvalid and every push is matched against the scoreboard queues.
    always @(negedge CLK) begin
        if (RSTN) begin
            if (req_seen || rsp.rvalid) begin
                chk("rvalid", 32'(rsp.rvalid), 32'(req_seen));
                if (rsp.rvalid) begin
                    if (rd_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rdata_extra: got 0x%0h, no response expected", rsp.rdata);
                    end else begin
                        chk("rdata", rsp.rdata, rd_q.pop_front());
                    end
                end
            end
            if (w_en) begin
                chk("push_while_full", 32'(full), 32'd0);
                push_rel_q.push_back(cyc - go_cyc);
                if (push_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL push_extra: got index %0d, no push expected", w_data);
                end else begin
                    chk("push_data", 32'(w_data), 32'(push_q.pop_front()));
                end
            end else begin
                chk("idle_data_zero", 32'(w_data), 32'd0);
            end
        end
    end

    function automatic bit mbit(input int i);
        return mwords[i / 32][i % 32];
    endfunction

    function automatic int count_bits();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(mbit(i));
        return c;
    endfunction

    // Scan position advances every cycle except when a set bit meets a full FIFO.
    function automatic int model_done_rel();
        int pos = 0;
        int k   = 0;
        while (pos < N && k < N*4) begin
            if (!(mbit(pos) && full_pat[k])) pos++;
            k++;
        end
        return k;
    endfunction

    function automatic logic [31:0] status_word(input bit b, input bit d, input int cnt);
        return (32'(cnt) << 8) | (32'(d) << 1) | 32'(b);
    endfunction

    task automatic expect_pushes(input int limit);
        for (int i = 0; i < limit; i++) if (mbit(i)) push_q.push_back(i);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic obi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        req.req = 1'b1; req.we = 1'b1; req.addr = addr; req.wdata = data; req.be = be;
        rd_q.push_back(32'h0);
        #1 chk("gnt_write", 32'(rsp.gnt), 32'd1);
        tick();
        req.req = 1'b0; req.we = 1'b0;
    endtask

    task automatic obi_read(input logic [31:0] addr, input logic [31:0] exp);
        req.req = 1'b1; req.we = 1'b0; req.addr = addr; req.wdata = '0; req.be = 4'hF;
        rd_q.push_back(exp);
        #1 chk("gnt_read", 32'(rsp.gnt), 32'd1);
        tick();
        req.req = 1'b0;
    endtask

    task automatic write_word(input int w, input logic [31:0] data, input logic [3:0] be);
        obi_write(32'(w * 4), data, be);
        if (!scanning) begin
            for (int b = 0; b < 4; b++) if (be[b]) mwords[w][8*b +: 8] = data[8*b +: 8];
        end
    endtask

    task automatic do_clear();
        obi_write(CtrlAddr, 32'h2, 4'hF);
        for (int w = 0; w < NW; w++) mwords[w] = '0;
        scanning = 0;
        full     = 1'b0;
        chk("busy_after_clear", 32'(busy), 32'd0);
        chk("done_after_clear", 32'(done), 32'd0);
    endtask

    task automatic do_go();
        push_rel_q.delete();
        obi_write(CtrlAddr, 32'h1, 4'hF);
        go_cyc   = cyc;
        scanning = 1;
        full     = full_pat[0];
        chk("done_cleared_on_go", 32'(done), 32'd0);
        chk("busy_on_go", 32'(busy), 32'd1);
    endtask

    task automatic run_scan(input int exp_rel);
        bit seen = 0;
        while (!seen && (cyc - go_cyc) < 3*N) begin
            @(negedge CLK);
            if (done) begin
                seen = 1;
            end else begin
                chk("busy_in_scan", 32'(busy), 32'd1);
                tick();
                full = full_pat[cyc - go_cyc];
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout: done low after +%0d cycles, required at +%0d",
                     cyc - go_cyc, exp_rel);
        end else if (cyc - go_cyc != exp_rel) begin
            errors++;
            $display("FAIL done_latency: rose at +%0d, required +%0d", cyc - go_cyc, exp_rel);
        end
        if (seen) chk("busy_at_done", 32'(busy), 32'd0);
        tick();
        full     = 1'b0;
        scanning = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req  = '0;
        full = 1'b0;
        for (int w = 0; w < NW; w++) mwords[w] = '0;
        for (int k = 0; k < N*4; k++) full_pat[k] = 0;

        // Reset state
        repeat (2) tick();
        chk("rst_w_en", 32'(w_en), 32'd0);
        chk("rst_w_data", 32'(w_data), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rvalid", 32'(rsp.rvalid), 32'd0);
        chk("rst_rdata", rsp.rdata, 32'd0);
        RSTN = 1'b1;
        tick();
        obi_read(StatusAddr, 32'h0);

        // Single spike on neuron 37
        write_word(1, 32'h0000_0020, 4'hF);
        expect_pushes(N);
        do_go();
        run_scan(model_done_rel());
        chk("single_push_count", 32'(push_rel_q.size()), 32'd1);
        if (push_rel_q.size() > 0) chk("single_push_cycle", 32'(push_rel_q[0]), 32'd37);
        obi_read(StatusAddr, status_word(0, 1, 1));
        do_clear();

        // All ones with FIFO full during scan cycles 10..19
        for (int w = 0; w < NW; w++) write_word(w, 32'hFFFF_FFFF, 4'hF);
        for (int k = 10; k < 20; k++) full_pat[k] = 1;
        expect_pushes(N);
        do_go();
        run_scan(model_done_rel());
        chk("full_push_count", 32'(push_rel_q.size()), 32'd256);
        obi_read(StatusAddr, status_word(0, 1, count_bits()));
        for (int k = 0; k < N*4; k++) full_pat[k] = 0;

        // Empty bitmap, GO twice (second from DONE)
        do_clear();
        do_go();
        run_scan(model_done_rel());
        obi_read(StatusAddr, status_word(0, 1, 0));
        do_go();
        run_scan(model_done_rel());

        // CLEAR written during scan cycle 5
        do_clear();
        write_word(0, 32'hFFFF_FFFF, 4'hF);
        expect_pushes(6);
        do_go();
        repeat (5) tick();
        do_clear();
        repeat (3) tick();
        chk("clear_push_count", 32'(push_rel_q.size()), 32'd6);
        obi_read(32'h0, 32'h0);

        // GO and CLEAR together: CLEAR wins
        obi_write(CtrlAddr, 32'h3, 4'hF);
        chk("go_clear_busy", 32'(busy), 32'd0);

        // Byte enables, then a write dropped during a scan
        write_word(2, 32'hA5A5_A5A5, 4'b0011);
        obi_read(32'h8, mwords[2]);
        expect_pushes(N);
        do_go();
        write_word(2, 32'hFFFF_FFFF, 4'hF);
        obi_read(32'h8, mwords[2]);
        run_scan(model_done_rel());
        obi_read(32'h8, 32'h0000_A5A5);
        obi_read(32'h0000_00FC, 32'h0);

        // Randomized bitmaps and FIFO back-pressure
        for (int it = 0; it < 4; it++) begin
            do_clear();
            for (int w = 0; w < NW; w++) write_word(w, $urandom, 4'($urandom_range(0, 15)));
            for (int k = 0; k < N*4; k++) full_pat[k] = ($urandom_range(0, 3) == 0);
            obi_read(32'($urandom_range(0, NW - 1) * 4), 32'h0);
            void'(rd_q.pop_back());
            rd_q.push_back(mwords[(req.addr >> 2)]);
            expect_pushes(N);
            do_go();
            run_scan(model_done_rel());
            obi_read(StatusAddr, status_word(0, 1, count_bits()));
            for (int k = 0; k < N*4; k++) full_pat[k] = 0;
        end

        // Reset asserted mid-scan
        do_clear();
        for (int w = 0; w < NW; w++) write_word(w, 32'hFFFF_FFFF, 4'hF);
        expect_pushes(N);
        do_go();
        repeat (20) tick();
        RSTN = 1'b0;
        #1;
        chk("midrst_w_en", 32'(w_en), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        push_q.delete();
        for (int w = 0; w < NW; w++) mwords[w] = '0;
        scanning = 0;
        repeat (2) tick();
        RSTN = 1'b1;
        tick();
        obi_read(StatusAddr, 32'h0);
        obi_read(32'h0, 32'h0);

        repeat (2) tick();
        @(negedge CLK);
        chk("push_queue_drained", 32'(push_q.size()), 32'd0);
        chk("read_queue_drained", 32'(rd_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
